// File: rtl/rr_quiescer_if.sv
// rr_quiescer_if: stream bundle around a reconfigurable-region quiescer.
//
// Groups the three data links the quiescer touches plus the engine busy hint:
//   c_*    upstream producer -> quiescer (consumer side of the region boundary)
//   e_c_*  quiescer -> engine input
//   e_p_*  engine output -> quiescer
//   p_*    quiescer -> downstream consumer
//   e_busy engine still holds state not yet visible on its outputs
// Modports:
//   slave  - the quiescer's view
//   master - the surrounding environment (producer, engine, consumer)
interface rr_quiescer_if #(
   parameter int unsigned DW = 32
) ();

   logic          c_prdy;
   logic          c_crdy;
   logic          c_cerr;
   logic [DW-1:0] c_data;

   logic          e_c_prdy;
   logic          e_c_crdy;
   logic          e_c_cerr;
   logic [DW-1:0] e_c_data;

   logic          e_p_prdy;
   logic          e_p_crdy;
   logic [DW-1:0] e_p_data;

   logic          p_prdy;
   logic          p_crdy;
   logic [DW-1:0] p_data;

   logic          e_busy;

   modport slave (
      input  c_prdy, c_data, e_c_crdy, e_c_cerr, e_p_prdy, e_p_data, p_crdy, e_busy,
      output c_crdy, c_cerr, e_c_prdy, e_c_data, e_p_crdy, p_prdy, p_data
   );

   modport master (
      output c_prdy, c_data, e_c_crdy, e_c_cerr, e_p_prdy, e_p_data, p_crdy, e_busy,
      input  c_crdy, c_cerr, e_c_prdy, e_c_data, e_p_crdy, p_prdy, p_data
   );

endinterface

// File: rtl/rr_quiescer.sv
// rr_quiescer: region-side responder to the reconfiguration manager's
// rc_reqn/rc_ackn handshake.
//
// On a request, new input is blocked, in-flight items are allowed to drain
// out of the engine, a settle interval elapses, and then rc_ackn is driven low
// so the manager may isolate and reconfigure the region. Releasing rc_reqn
// resumes zero-latency pass-through.
//
// Ports:
//   clk          system clock
//   rstn         asynchronous active-low reset
//   rc_reqn      reconfiguration request (active-low, synchronous to clk)
//   rc_ackn      acknowledge (active-low, registered; low exactly in ACKED)
//   bus          stream bundle (rr_quiescer_if.slave)
//   outstanding  items accepted by the engine but not yet emitted
//   rc_tmo       drain-timeout flag
//
// Build option: define RC_TIMEOUT_EN to add a drain timeout of TIMEOUT_CYC
// cycles that forces ACKED and raises rc_tmo. Without it rc_tmo is tied 0
// and DRAIN may wait indefinitely.
module rr_quiescer #(
   parameter int unsigned DW          = 32,
   parameter int unsigned CW          = 4,
   parameter int unsigned SETTLE_CYC  = 4,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          rc_reqn,
   output logic          rc_ackn,
   rr_quiescer_if.slave  bus,
   output logic [CW-1:0] outstanding,
   output logic          rc_tmo
);

   localparam int unsigned SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [SW-1:0] SETTLE_LOAD = (SETTLE_CYC > 0) ? SW'(SETTLE_CYC - 1) : '0;

   typedef enum logic [1:0] {
      StRun,
      StDrain,
      StSettle,
      StAcked
   } state_e;

   state_e         state_q, state_d;
   logic [SW-1:0]  settle_q, settle_d;
   logic [CW-1:0]  outstanding_q, outstanding_d;
   logic           rc_ackn_q;

   logic           in_gate;
   logic           out_gate;
   logic           in_xfer;
   logic           out_xfer;
   logic           drained;
   logic           tmo_hit;

   logic [DW-1:0]  fwd_data;
   logic [DW-1:0]  ret_data;

   // Gates and transfer qualifiers
   assign in_gate  = (state_q == StRun) && (outstanding_q != '1);
   assign out_gate = (state_q != StAcked);
   assign in_xfer  = bus.c_prdy & bus.e_c_crdy & in_gate;
   assign out_xfer = bus.e_p_prdy & bus.p_crdy & out_gate;

   // Engine is empty only when nothing is counted, nothing is hidden inside
   // it and nothing is waiting on its output.
   assign drained  = (outstanding_q == '0) & ~bus.e_busy & ~bus.e_p_prdy;

   assign fwd_data = bus.c_data;
   assign ret_data = bus.e_p_data;

`ifdef RC_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic          rc_tmo_q, rc_tmo_d;

   // Counts every cycle spent quiescing; it is held at zero in RUN, so each
   // request starts counting from DRAIN entry and a SETTLE->DRAIN bounce does
   // not restart the budget.
   assign tmo_hit = ((state_q == StDrain) || (state_q == StSettle)) &&
                    (tmo_cnt_q == TW'(TIMEOUT_CYC - 1));

   always_comb begin
      tmo_cnt_d = tmo_cnt_q;
      if (state_q == StRun) begin
         tmo_cnt_d = '0;
      end else if ((state_q == StDrain) || (state_q == StSettle)) begin
         tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
   end

   always_comb begin
      rc_tmo_d = rc_tmo_q;
      if (state_d == StRun) begin
         rc_tmo_d = 1'b0;
      end else if (tmo_hit && (state_d == StAcked)) begin
         rc_tmo_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         tmo_cnt_q <= '0;
         rc_tmo_q  <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         rc_tmo_q  <= rc_tmo_d;
      end
   end

   assign rc_tmo = rc_tmo_q;
`else
   assign tmo_hit = 1'b0;
   assign rc_tmo  = 1'b0;
`endif

   // FSM: state register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= StRun;
         settle_q  <= '0;
         rc_ackn_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         settle_q  <= settle_d;
         // Registered from next state so rc_ackn is low exactly in ACKED
         rc_ackn_q <= (state_d != StAcked);
      end
   end

   // FSM: next state
   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      unique case (state_q)
         StRun: begin
            if (!rc_reqn) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (rc_reqn) begin
               state_d = StRun;
            end else if (tmo_hit) begin
               state_d = StAcked;
            end else if (drained) begin
               if (SETTLE_CYC == 0) begin
                  state_d = StAcked;
               end else begin
                  state_d  = StSettle;
                  settle_d = SETTLE_LOAD;
               end
            end
         end
         StSettle: begin
            if (rc_reqn) begin
               state_d = StRun;
            end else if (tmo_hit) begin
               state_d = StAcked;
            end else if (bus.e_busy || bus.e_p_prdy) begin
               // Engine woke up again; settle restarts after the next drain
               state_d = StDrain;
            end else if (settle_q == '0) begin
               state_d = StAcked;
            end else begin
               settle_d = settle_q - 1'b1;
            end
         end
         StAcked: begin
            if (rc_reqn) begin
               state_d = StRun;
            end
         end
         default: begin
            state_d = StRun;
         end
      endcase
   end

   // FSM: outputs and gated datapath
   always_comb begin
      bus.e_c_prdy = bus.c_prdy & in_gate;
      bus.c_crdy   = bus.e_c_crdy & in_gate;
      bus.c_cerr   = bus.e_c_cerr & (state_q == StRun);
      bus.e_c_data = fwd_data;
      bus.p_prdy   = bus.e_p_prdy & out_gate;
      bus.e_p_crdy = bus.p_crdy & out_gate;
      bus.p_data   = ret_data;
      rc_ackn      = rc_ackn_q;
      outstanding  = outstanding_q;
   end

   // Outstanding-item counter; saturation is prevented by in_gate and an
   // output at zero holds zero.
   always_comb begin
      outstanding_d = outstanding_q;
      if (in_xfer && !out_xfer) begin
         outstanding_d = outstanding_q + 1'b1;
      end else if (out_xfer && !in_xfer && (outstanding_q != '0)) begin
         outstanding_d = outstanding_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         outstanding_q <= '0;
      end else begin
         outstanding_q <= outstanding_d;
      end
   end

endmodule

// File: tb/tb_rr_quiescer.sv
// tb_rr_quiescer: directed bench for rr_quiescer.
//
// u_dut  : DW=32, CW=4, SETTLE_CYC=4, TIMEOUT_CYC=16 (main scenarios)
// u_dut2 : CW=2 instance for counter saturation
// Downstream beats on u_dut are checked by a monitor against a queue of
// expected data filled by the stimulus.
module tb_rr_quiescer;

   localparam int unsigned DW = 32;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          rc_reqn;
   logic          rc_ackn;
   logic          rc_tmo;
   logic [3:0]    outstanding;
   logic          rc_reqn2;
   logic          rc_ackn2;
   logic          rc_tmo2;
   logic [1:0]    outstanding2;

   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] mon_exp;

   rr_quiescer_if #(.DW(DW)) bus1 ();
   rr_quiescer_if #(.DW(DW)) bus2 ();

   always #5 clk = ~clk;

   rr_quiescer #(
      .DW          (DW),
      .CW          (4),
      .SETTLE_CYC  (4),
      .TIMEOUT_CYC (16)
   ) u_dut (
      .clk         (clk),
      .rstn        (rstn),
      .rc_reqn     (rc_reqn),
      .rc_ackn     (rc_ackn),
      .bus         (bus1.slave),
      .outstanding (outstanding),
      .rc_tmo      (rc_tmo)
   );

   rr_quiescer #(
      .DW          (DW),
      .CW          (2),
      .SETTLE_CYC  (4),
      .TIMEOUT_CYC (16)
   ) u_dut2 (
      .clk         (clk),
      .rstn        (rstn),
      .rc_reqn     (rc_reqn2),
      .rc_ackn     (rc_ackn2),
      .bus         (bus2.slave),
      .outstanding (outstanding2),
      .rc_tmo      (rc_tmo2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Downstream monitor: every beat leaving u_dut must match the queue head
   always @(negedge clk) begin
      if (rstn && bus1.p_prdy && bus1.p_crdy) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL p_data_unexpected: got %0h, expected no beat (t=%0t)",
                     bus1.p_data, $time);
         end else begin
            mon_exp = exp_q.pop_front();
            if (bus1.p_data !== mon_exp) begin
               errors++;
               $display("FAIL p_data: got %0h, expected %0h (t=%0t)",
                        bus1.p_data, mon_exp, $time);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rc_reqn       = 1'b1;
      rc_reqn2      = 1'b1;
      bus1.c_prdy   = 1'b0;
      bus1.c_data   = '0;
      bus1.e_c_crdy = 1'b1;
      bus1.e_c_cerr = 1'b0;
      bus1.e_p_prdy = 1'b0;
      bus1.e_p_data = '0;
      bus1.p_crdy   = 1'b1;
      bus1.e_busy   = 1'b0;
      bus2.c_prdy   = 1'b0;
      bus2.c_data   = '0;
      bus2.e_c_crdy = 1'b1;
      bus2.e_c_cerr = 1'b0;
      bus2.e_p_prdy = 1'b0;
      bus2.e_p_data = '0;
      bus2.p_crdy   = 1'b1;
      bus2.e_busy   = 1'b0;

      // Reset values
      #12;
      check("rst_ackn", rc_ackn, 1);
      check("rst_outstanding", outstanding, 0);
      check("rst_tmo", rc_tmo, 0);
      check("rst_c_crdy", bus1.c_crdy, 1);
      check("rst_p_prdy", bus1.p_prdy, 0);
      check("rst_outstanding2", outstanding2, 0);
      tick();
      rstn = 1'b1;
      tick();

      // Idle engine: ack 2+SETTLE_CYC edges after rc_reqn is driven low
      rc_reqn = 1'b0;
      tick();
      check("drain_c_crdy", bus1.c_crdy, 0);
      check("drain_ackn", rc_ackn, 1);
      repeat (4) tick();
      check("settle_ackn_still_high", rc_ackn, 1);
      tick();
      check("idle_ack_latency", rc_ackn, 0);
      bus1.e_p_prdy = 1'b1;
      #1;
      check("acked_p_prdy_gated", bus1.p_prdy, 0);
      check("acked_e_p_crdy_gated", bus1.e_p_crdy, 0);
      check("acked_c_crdy", bus1.c_crdy, 0);
      bus1.e_p_prdy = 1'b0;
      repeat (3) tick();
      check("acked_hold", rc_ackn, 0);
      rc_reqn = 1'b1;
      tick();
      check("release_ackn", rc_ackn, 1);
      check("release_c_crdy", bus1.c_crdy, 1);
      bus1.c_prdy = 1'b1;
      bus1.c_data = 32'hA5A5_0001;
      #1;
      check("pass_e_c_prdy", bus1.e_c_prdy, 1);
      check("pass_e_c_data", bus1.e_c_data, 32'hA5A5_0001);
      tick();
      bus1.c_prdy = 1'b0;
      check("pass_outstanding_1", outstanding, 1);
      bus1.e_p_prdy = 1'b1;
      bus1.e_p_data = 32'hDEAD_0001;
      exp_q.push_back(32'hDEAD_0001);
      tick();
      bus1.e_p_prdy = 1'b0;
      check("pass_outstanding_0", outstanding, 0);

      // CW=2 saturation and simultaneous in/out
      bus2.c_prdy = 1'b1;
      bus2.c_data = 32'h0000_0055;
      repeat (3) tick();
      check("sat_outstanding2", outstanding2, 3);
      check("sat_c_crdy", bus2.c_crdy, 0);
      check("sat_e_c_prdy", bus2.e_c_prdy, 0);
      bus2.e_p_prdy = 1'b1;
      bus2.e_p_data = 32'h0000_0077;
      #1;
      check("sat_p_data", bus2.p_data, 32'h77);
      tick();
      bus2.e_p_prdy = 1'b0;
      check("unsat_outstanding2", outstanding2, 2);
      check("unsat_c_crdy", bus2.c_crdy, 1);
      bus2.e_c_crdy = 1'b0;
      #1;
      check("unsat_c_crdy_follows", bus2.c_crdy, 0);
      bus2.e_c_crdy = 1'b1;
      bus2.e_p_prdy = 1'b1;
      tick();
      check("simul_inout_outstanding2", outstanding2, 2);
      bus2.c_prdy = 1'b0;
      repeat (3) tick();
      bus2.e_p_prdy = 1'b0;
      check("no_underflow_outstanding2", outstanding2, 0);

      // Drain with 3 items in flight
      bus1.c_prdy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus1.c_data = 32'h100 + i;
         tick();
      end
      bus1.c_prdy = 1'b0;
      check("drain_outstanding_3", outstanding, 3);
      bus1.e_c_cerr = 1'b1;
      #1;
      check("run_c_cerr", bus1.c_cerr, 1);
      bus1.e_busy = 1'b1;
      rc_reqn = 1'b0;
      tick();
      check("drain_c_cerr", bus1.c_cerr, 0);
      bus1.e_c_cerr = 1'b0;
      repeat (3) tick();
      check("drain_hold_ackn", rc_ackn, 1);
      check("drain_hold_outstanding", outstanding, 3);
      for (int i = 0; i < 3; i++) begin
         bus1.e_p_prdy = 1'b1;
         bus1.e_p_data = 32'h200 + i;
         exp_q.push_back(32'h200 + i);
         tick();
      end
      bus1.e_p_prdy = 1'b0;
      check("drained_outstanding", outstanding, 0);
      tick();
      check("busy_hold_ackn", rc_ackn, 1);
      bus1.e_busy = 1'b0;
      repeat (4) tick();
      check("drain_settle_ackn_high", rc_ackn, 1);
      tick();
      check("drain_ack_latency", rc_ackn, 0);
      rc_reqn = 1'b1;
      tick();
      check("drain_release_ackn", rc_ackn, 1);

      // Abort during SETTLE
      rc_reqn = 1'b0;
      repeat (3) tick();
      rc_reqn = 1'b1;
      tick();
      check("abort_c_crdy", bus1.c_crdy, 1);
      for (int i = 0; i < 6; i++) begin
         check("abort_ackn_high", rc_ackn, 1);
         tick();
      end

      // e_busy pulse in SETTLE restarts the settle count
      rc_reqn = 1'b0;
      repeat (3) tick();
      bus1.e_busy = 1'b1;
      tick();
      bus1.e_busy = 1'b0;
      tick();
      repeat (3) tick();
      check("resettle_ackn_high", rc_ackn, 1);
      tick();
      check("resettle_ackn_low", rc_ackn, 0);
      rc_reqn = 1'b1;
      tick();

      // Reset mid-drain
      bus1.c_prdy = 1'b1;
      repeat (2) tick();
      bus1.c_prdy = 1'b0;
      check("rst_drain_pre_outstanding", outstanding, 2);
      rc_reqn = 1'b0;
      repeat (2) tick();
      rc_reqn = 1'b1;
      rstn = 1'b0;
      #1;
      check("rst_drain_outstanding", outstanding, 0);
      check("rst_drain_c_crdy", bus1.c_crdy, 1);
      tick();
      rstn = 1'b1;
      tick();

      // Reset in SETTLE
      rc_reqn = 1'b0;
      repeat (3) tick();
      rstn = 1'b0;
      rc_reqn = 1'b1;
      #1;
      check("rst_settle_ackn", rc_ackn, 1);
      check("rst_settle_c_crdy", bus1.c_crdy, 1);
      tick();
      rstn = 1'b1;
      tick();
      check("rst_settle_run", bus1.c_crdy, 1);

      // Reset in ACKED
      rc_reqn = 1'b0;
      repeat (6) tick();
      check("rst_acked_pre_ackn", rc_ackn, 0);
      rstn = 1'b0;
      rc_reqn = 1'b1;
      #1;
      check("rst_acked_ackn", rc_ackn, 1);
      check("rst_acked_outstanding", outstanding, 0);
      tick();
      rstn = 1'b1;
      tick();
      check("rst_acked_run", bus1.c_crdy, 1);
      check("rst_acked_ackn_after", rc_ackn, 1);

      // Stuck engine
      bus1.e_busy = 1'b1;
      rc_reqn = 1'b0;
      tick();
`ifdef RC_TIMEOUT_EN
      repeat (15) tick();
      check("tmo_pre_ackn", rc_ackn, 1);
      check("tmo_pre_flag", rc_tmo, 0);
      tick();
      check("tmo_ackn", rc_ackn, 0);
      check("tmo_flag", rc_tmo, 1);
      tick();
      check("tmo_flag_hold", rc_tmo, 1);
      rc_reqn = 1'b1;
      tick();
      check("tmo_flag_clear", rc_tmo, 0);
      check("tmo_release_ackn", rc_ackn, 1);
`else
      repeat (40) tick();
      check("stuck_ackn_high", rc_ackn, 1);
      check("stuck_tmo_zero", rc_tmo, 0);
      rc_reqn = 1'b1;
      tick();
      check("stuck_release_c_crdy", bus1.c_crdy, 1);
`endif
      bus1.e_busy = 1'b0;
      tick();

      check("scoreboard_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rr_quiescer.md
Name: rr_quiescer

Overview:
- Region-side responder to the reconfiguration manager's per-region request/acknowledge handshake (rc_reqn/rc_ackn).
- Sits inside a reconfigurable region, between the region boundary (producer/consumer interface) and the user engine.
- On request: blocks new consumer input, lets in-flight items drain out of the engine, waits a settle interval, then acknowledges so the manager can isolate and reconfigure.
- On release: resumes normal pass-through.

Parameters:
- DW, 32: producer/consumer data width.
- CW, 4: outstanding-item counter width; at most 2^CW-1 items in flight.
- SETTLE_CYC, 4: idle cycles between drain complete and ack; 0 = no settle wait.
- TIMEOUT_CYC, 1024: drain timeout in cycles; used only with RC_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset; asynchronous assert, active-low.
- rc_reqn  in  1  reconfiguration request from manager, active-low, synchronous to clk.
- rc_ackn  out  1  acknowledge to manager, active-low, registered.
- c_prdy  in  1  upstream producer ready (valid).
- c_crdy  out  1  consumer ready toward upstream.
- c_cerr  out  1  consumer error toward upstream.
- c_data  in  DW  upstream data.
- e_c_prdy  out  1  valid into engine.
- e_c_crdy  in  1  engine ready.
- e_c_cerr  in  1  engine consumer error.
- e_c_data  out  DW  data into engine.
- e_p_prdy  in  1  engine output valid.
- e_p_crdy  out  1  ready to engine.
- e_p_data  in  DW  engine output data.
- p_prdy  out  1  output valid toward downstream consumer.
- p_crdy  in  1  downstream ready.
- p_data  out  DW  output data.
- e_busy  in  1  engine holds internal state not yet reflected in outputs.
- outstanding  out  CW  items accepted but not yet emitted.
- rc_tmo  out  1  drain timeout flag; tied 0 without RC_TIMEOUT_EN.

Behaviour:
- Transfer rule: a beat transfers on a clk edge where prdy and crdy are both high on the same link.
- Datapath is combinational, zero latency. Data passes unmodified: e_c_data=c_data, p_data=e_p_data.
- in_gate = (state==RUN) and (outstanding != 2^CW-1).
  - e_c_prdy = c_prdy & in_gate
  - c_crdy = e_c_crdy & in_gate
  - c_cerr = e_c_cerr & (state==RUN)
- out_gate = (state != ACKED).
  - p_prdy = e_p_prdy & out_gate
  - e_p_crdy = p_crdy & out_gate
- outstanding counter:
  - +1 on input transfer only; -1 on output transfer only.
  - Both in the same cycle: unchanged.
  - An output transfer at 0 holds 0 (no underflow).
  - The saturation value blocks input through in_gate.
- FSM states: RUN, DRAIN, SETTLE, ACKED. Reset state is RUN.
  - RUN: rc_reqn==0 sampled -> DRAIN.
  - DRAIN: rc_reqn==1 -> RUN (abort). Else, if outstanding==0 & !e_busy & !e_p_prdy -> SETTLE (load settle counter with SETTLE_CYC-1), or -> ACKED directly when SETTLE_CYC==0.
  - SETTLE: rc_reqn==1 -> RUN. If e_busy or e_p_prdy rises -> DRAIN. Counter==0 -> ACKED. Else decrement.
  - ACKED: rc_ackn=0 while in this state. rc_reqn==1 -> RUN; rc_ackn returns to 1 on that same edge.
- rc_ackn is registered and equals 0 exactly while the state is ACKED. Latency from rc_reqn falling to rc_ackn falling with an idle engine is 2+SETTLE_CYC cycles.
- Abort before ACKED: rc_ackn never pulses and the counter is unaffected.
- Reset (any time, including mid-drain):
  - state=RUN, rc_ackn=1, outstanding=0, settle counter=0, rc_tmo=0.
  - All gated outputs follow the combinational rules above.

Optional Feature:
- Macro RC_TIMEOUT_EN.
  - Defined: a timeout counter clears on entry to DRAIN and increments in DRAIN/SETTLE. On reaching TIMEOUT_CYC, the FSM goes to ACKED regardless of drain status and rc_tmo is set to 1. rc_tmo stays 1 until the next return to RUN, then clears.
  - Undefined: no timeout counter; DRAIN can wait indefinitely; rc_tmo is constant 0.

Test Plan:
- Idle engine, SETTLE_CYC=4: drive rc_reqn low at cycle 10 -> rc_ackn falls at cycle 16. c_crdy=0 from cycle 11. Drive rc_reqn high at cycle 30 -> rc_ackn=1 at the cycle 31 edge and pass-through resumes.
- Accept 3 items (outstanding=3), then request -> DRAIN holds. After 3 output transfers and e_busy=0, ack follows 1+SETTLE_CYC cycles later. outstanding reads 0.
- CW=2: 3 accepted with no outputs -> c_crdy forced 0. One output transfer -> c_crdy follows e_c_crdy again. Simultaneous in/out transfer leaves the count unchanged.
- Request, then release rc_reqn during SETTLE (cycle 2 of 4) -> return to RUN, rc_ackn stays 1 throughout. Also pulse e_busy during SETTLE -> back to DRAIN, and the settle count restarts on the next drain completion.
- Assert rstn=0 in SETTLE and in ACKED -> rc_ackn=1 and outstanding=0 immediately; state is RUN after rstn is released.
- RC_TIMEOUT_EN, TIMEOUT_CYC=16, e_busy stuck at 1: request -> rc_ackn=0 and rc_tmo=1 16 cycles after DRAIN entry. rc_tmo clears after rc_reqn returns high.
